// File: rtl/seg_decode_pkg.sv
// Segment-pattern and ASCII constants plus the pattern-to-character decoder
// shared by the 7-segment message capture stage.
package seg_decode_pkg;

  typedef struct packed {
    logic dp;
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  typedef struct packed {
    logic       known;
    logic [7:0] ch;
  } decode_t;

  localparam logic [6:0] PAT_H = 7'h76;
  localparam logic [6:0] PAT_E = 7'h79;
  localparam logic [6:0] PAT_L = 7'h38;
  localparam logic [6:0] PAT_O = 7'h3F;
  localparam logic [6:0] PAT_P = 7'h73;
  localparam logic [6:0] PAT_R = 7'h50;
  localparam logic [6:0] PAT_G = 7'h3D;
  localparam logic [6:0] PAT_1 = 7'h06;
  localparam logic [6:0] PAT_2 = 7'h5B;
  localparam logic [6:0] PAT_3 = 7'h4F;
  localparam logic [6:0] PAT_4 = 7'h66;
  localparam logic [6:0] PAT_5 = 7'h6D;
  localparam logic [6:0] PAT_6 = 7'h7D;
  localparam logic [6:0] PAT_7 = 7'h07;
  localparam logic [6:0] PAT_8 = 7'h7F;
  localparam logic [6:0] PAT_9 = 7'h6F;

  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_O = 8'h4F;
  localparam logic [7:0] CH_P = 8'h50;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_G = 8'h47;
  localparam logic [7:0] CH_1 = 8'h31;
  localparam logic [7:0] CH_2 = 8'h32;
  localparam logic [7:0] CH_3 = 8'h33;
  localparam logic [7:0] CH_4 = 8'h34;
  localparam logic [7:0] CH_5 = 8'h35;
  localparam logic [7:0] CH_6 = 8'h36;
  localparam logic [7:0] CH_7 = 8'h37;
  localparam logic [7:0] CH_8 = 8'h38;
  localparam logic [7:0] CH_9 = 8'h39;

  localparam logic [7:0] BLANK        = 8'h00;
  localparam logic [7:0] UNKNOWN_CHAR = 8'h3F;

  // 0x3F is deliberately 'O': the message set never shows a zero digit.
  function automatic decode_t seg_to_ascii(input logic [6:0] seg);
    decode_t r;
    r.known = 1'b1;
    case (seg)
      PAT_H:   r.ch = CH_H;
      PAT_E:   r.ch = CH_E;
      PAT_L:   r.ch = CH_L;
      PAT_O:   r.ch = CH_O;
      PAT_P:   r.ch = CH_P;
      PAT_R:   r.ch = CH_R;
      PAT_G:   r.ch = CH_G;
      PAT_1:   r.ch = CH_1;
      PAT_2:   r.ch = CH_2;
      PAT_3:   r.ch = CH_3;
      PAT_4:   r.ch = CH_4;
      PAT_5:   r.ch = CH_5;
      PAT_6:   r.ch = CH_6;
      PAT_7:   r.ch = CH_7;
      PAT_8:   r.ch = CH_8;
      PAT_9:   r.ch = CH_9;
      default: begin
        r.known = 1'b0;
        r.ch    = UNKNOWN_CHAR;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_msg_capture_if.sv
// Segment input plus decoded-character valid/ready port of the capture stage.
interface seg_msg_capture_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    seg_in;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_char;
  logic          out_dp;
  logic [CW-1:0] count;
  logic          unknown;
  logic          overflow;

  modport master (
    output seg_in, out_ready,
    input  out_valid, out_char, out_dp, count, unknown, overflow
  );

  modport slave (
    input  seg_in, out_ready,
    output out_valid, out_char, out_dp, count, unknown, overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: push/full write side, valid/ready read side, occupancy count.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_pop  = rd_valid && rd_ready;
  assign do_push = wr_valid && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/seg_msg_capture.sv
// Captures stable 7-segment patterns, decodes them to ASCII and queues the
// characters; blank patterns act as separators so repeated letters survive.
module seg_msg_capture
  import seg_decode_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 8
) (
  input  logic              clk,
  input  logic              reset,
  seg_msg_capture_if.slave  bus
);
  localparam int         CW     = $clog2(DEPTH) + 1;
  localparam logic [7:0] SC_MAX = 8'(STABLE_CYCLES);

  seg_t          s_q, s_d;
  seg_t          last_q, last_d;
  logic [7:0]    sc_q, sc_d;
  logic          unknown_q, unknown_d;
  logic          overflow_q, overflow_d;

  logic          accept, blank, push_req, do_pop;
  decode_t       dec;
  logic          fifo_full, fifo_valid;
  logic [8:0]    fifo_rd_data;
  logic [CW-1:0] fifo_count;

  // Accept fires only on the edge the count first saturates, so a held
  // pattern is taken once per stable period.
  always_comb begin
    s_d  = seg_t'(bus.seg_in);
    sc_d = sc_q;
    if (s_d != s_q) begin
      sc_d = 8'd1;
    end else if (sc_q != SC_MAX) begin
      sc_d = sc_q + 8'd1;
    end

    accept   = (sc_q != SC_MAX) && (sc_d == SC_MAX) && (s_q != last_q);
    blank    = (s_q[6:0] == BLANK[6:0]);
    dec      = seg_to_ascii(s_q[6:0]);
    push_req = accept && !blank;
    do_pop   = fifo_valid && bus.out_ready;

    last_d     = accept ? s_q : last_q;
    unknown_d  = unknown_q | (push_req && !dec.known);
    overflow_d = overflow_q | (push_req && fifo_full && !do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q        <= '0;
      sc_q       <= '0;
      last_q     <= '0;
      unknown_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      sc_q       <= sc_d;
      last_q     <= last_d;
      unknown_q  <= unknown_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (push_req),
    .wr_data  ({s_q.dp, dec.ch}),
    .full     (fifo_full),
    .rd_valid (fifo_valid),
    .rd_ready (bus.out_ready),
    .rd_data  (fifo_rd_data),
    .count    (fifo_count)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_char  = fifo_valid ? fifo_rd_data[7:0] : '0;
  assign bus.out_dp    = fifo_valid ? fifo_rd_data[8] : 1'b0;
  assign bus.count     = fifo_count;
  assign bus.unknown   = unknown_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: doc/seg_msg_capture.md
# seg_msg_capture

Downstream capture stage for the 7-segment message generator on the Tiny Tapeout user slot. Consumes the 8-bit segment output (`io_out`), waits for each pattern to be stable, decodes it back to ASCII and queues the characters in a small FIFO with a valid/ready port. Used as an on-chip or bench-side checker, so message sequences ("HELLO", "RPOG") can be compared as characters instead of raw segment bits.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required to accept a pattern; legal range 2..255.
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high; clears all state on the clock edge where it is high.
- `seg_in` in 8: segment bus, bit0=a … bit6=g, bit7=dp.
- `out_valid` out 1: FIFO head holds a character.
- `out_ready` in 1: consumer accepts the head when `out_valid` is also high.
- `out_char` out 8: ASCII of the head entry; 0x00 when `out_valid`=0.
- `out_dp` out 1: dp bit captured with the head entry; 0 when empty.
- `count` out clog2(DEPTH)+1: current FIFO occupancy.
- `unknown` out 1: sticky; set when an undecodable pattern is accepted.
- `overflow` out 1: sticky; set when a character is dropped because the FIFO is full.

## Operation
- Sample register `s` takes `seg_in` every edge. Stability counter `sc` (saturating at `STABLE_CYCLES`): reloads to 1 when the new sample ≠ `s`, otherwise increments.
- Accept event: the edge on which `sc` reaches `STABLE_CYCLES` (one event per stable period, never repeated while saturated), and the 8-bit pattern ≠ `last`. On accept, `last` ← pattern.
- Blank pattern (bits 6:0 = 0) is accepted as a separator: updates `last`, pushes nothing. This lets repeated letters (the "LL" in HELLO) be captured when separated by blank or by a dp change.
- Decode of bits 6:0: 0x76→'H', 0x79→'E', 0x38→'L', 0x3F→'O', 0x73→'P', 0x50→'R' (lower r), 0x3D→'G', 0x06→'1', 0x5B→'2', 0x4F→'3', 0x66→'4', 0x6D→'5', 0x7D→'6', 0x07→'7', 0x7F→'8', 0x6F→'9'. Anything else → '?' (0x3F) and sets `unknown`. 0x3F always decodes to 'O', never '0'.
- Push: decoded char + dp written to FIFO. Pop: `out_valid && out_ready`.
- Full and push without pop: char dropped, FIFO unchanged, `overflow` set. Full with simultaneous push and pop: both occur, no drop, `count` stays DEPTH. Empty with push: pop is not possible that edge (no bypass).
- Pointers wrap modulo DEPTH; `count` = push − pop, never exceeds DEPTH.
- Reset values: `s`=0, `sc`=0, `last`=0x00 (blank, so the first non-blank pattern is accepted), FIFO empty, `out_valid`=0, `out_char`=0, `out_dp`=0, `count`=0, `unknown`=0, `overflow`=0. Reset mid-stream discards queued characters and any partial stability count.

## Timing
- Pattern present before edge k and held: `s` loads at edge k (`sc`=1), accept at edge k+STABLE_CYCLES−1, `out_valid` high after that edge (empty FIFO). Latency = STABLE_CYCLES edges from first sampling edge.
- Glitch shorter than STABLE_CYCLES samples: ignored, restarts the count.
- `out_char`/`out_dp` are combinational from the head entry; stable while `out_valid`=1 and `out_ready`=0.
- `count` and flags update on the same edge as the push/pop causing them.

## Structure
- Package `seg_decode_pkg`: segment bit indices, the 16 pattern constants, ASCII constants, BLANK=0x00, UNKNOWN_CHAR=0x3F, and a pure `seg_to_ascii` function returning {known, char}.
- Sub-module `sync_fifo` (parameters WIDTH=9, DEPTH): valid/ready read side, push/full write side, count output; drop/overflow policy lives in the top.

## Test plan
- Reset then H,E,L,blank,L,O each held 6 cycles, `out_ready`=1 → chars 0x48,0x45,0x4C,0x4C,0x4F, `unknown`=0.
- Pattern 0x76 held 3 cycles then 0x79 held 4 (STABLE_CYCLES=4) → only 'E' pushed, 4 edges after 0x79 first sampled.
- Push 9 distinct chars with `out_ready`=0, DEPTH=8 → `count`=8, `overflow`=1, head 'first char'; then pop all → exactly the first 8 in order.
- Full FIFO, push and pop on the same edge → no drop, `overflow` stays 0, `count`=8.
- Pattern 0x01 accepted → `out_char`=0x3F, `unknown`=1 until reset.
- Reset asserted with 3 entries queued and a pattern mid-count → next edge `count`=0, `out_valid`=0; same pattern held afterwards is re-accepted.
